dmem_ctrl: RTL

- Parametrised single-port data memory with a valid/ready request port, per-byte write strobes and a fixed-latency response pipeline.
- Replaces the fixed 128x32 data memory; sits between the core's load/store stage and on-chip RAM.
- Clears its contents with a post-reset sweep FSM instead of a wide parallel reset, so the array maps to block RAM.
- Flags misaligned and out-of-range accesses.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory controller.
package dmem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest supported word; response structs carry data at this width.
  localparam int MAX_DATA_W = 64;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [MAX_DATA_W-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port byte-enable RAM with registered read and no reset,
// so it maps onto block RAM.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 128,
  localparam int IDX_W  = idx_w(DEPTH),
  localparam int BPW    = bytes_per_word(DATA_W)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BPW-1:0]    be,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BPW; b++) begin
          if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: post-reset clearing sweep, address decode with error
// flagging, and a fixed-latency in-order response pipeline. Defining
// DMEM_STATS_EN adds read/write/error access counters.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 128,
  parameter  int ADDR_W = 32,
  parameter  int RD_LAT = 1,
  localparam int BPW    = bytes_per_word(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BPW-1:0]    req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt,
  output logic [31:0]       err_cnt
`endif
);

  localparam int          OFF_W      = off_bits(DATA_W);
  localparam int          IDX_W      = idx_w(DEPTH);
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'(BPW);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               accept, mis, oor, err, clr_ok, in_init;
  logic [IDX_W-1:0]   req_idx;

  logic               ram_en, ram_we;
  logic [BPW-1:0]     ram_be;
  logic [IDX_W-1:0]   ram_addr;
  logic [DATA_W-1:0]  ram_wdata, ram_rdata;

  logic               vld_p0, we_p0, err_p0;
  logic               vld_p1, err_p1;
  logic [DATA_W-1:0]  rdata_p1;
  rsp_t               rsp_p0, rsp_out;

  assign in_init   = (state_q == INIT);
  assign req_ready = (state_q == RUN);
  assign init_done = (state_q == RUN);
  assign accept    = req_valid & req_ready;
  assign clr_ok    = req_ready & clr & ~req_valid;

  assign mis     = |req_addr[OFF_W-1:0];
  assign oor     = 64'(req_addr) >= ADDR_LIMIT;
  assign err     = mis | oor;
  assign req_idx = IDX_W'(req_addr >> OFF_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = RUN;
          ptr_d   = '0;
        end
      end
      RUN: begin
        if (clr_ok) begin
          state_d = INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // The sweep owns the RAM port during INIT; erroring requests never reach it.
  assign ram_en    = in_init | (accept & ~err);
  assign ram_we    = in_init | req_we;
  assign ram_be    = in_init ? '1 : req_be;
  assign ram_addr  = in_init ? ptr_q : req_idx;
  assign ram_wdata = in_init ? '0 : req_wdata;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Stage p0: acceptance edge; RAM read data lands alongside these flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    we_p0  <= req_we;
    err_p0 <= err;
  end

  always_comb begin
    rsp_p0.valid = vld_p0;
    rsp_p0.err   = err_p0;
    rsp_p0.rdata = (we_p0 | err_p0) ? '0 : MAX_DATA_W'(ram_rdata);
  end

  // Stage p1: response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= rsp_p0.valid;
  end

  always_ff @(posedge clk) begin
    err_p1   <= rsp_p0.err;
    rdata_p1 <= DATA_W'(rsp_p0.rdata);
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              vld_p2, err_p2;
      logic [DATA_W-1:0] rdata_p2;

      // Stage p2: extra output register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p2 <= 1'b0;
        else        vld_p2 <= vld_p1;
      end

      always_ff @(posedge clk) begin
        err_p2   <= err_p1;
        rdata_p2 <= rdata_p1;
      end

      always_comb begin
        rsp_out.valid = vld_p2;
        rsp_out.err   = err_p2;
        rsp_out.rdata = MAX_DATA_W'(rdata_p2);
      end
    end else begin : g_lat1
      always_comb begin
        rsp_out.valid = vld_p1;
        rsp_out.err   = err_p1;
        rsp_out.rdata = MAX_DATA_W'(rdata_p1);
      end
    end
  endgenerate

  // Data registers are unreset; gating with valid keeps outputs at 0 when idle.
  assign rsp_valid = rsp_out.valid;
  assign rsp_err   = rsp_out.valid & rsp_out.err;
  assign rsp_rdata = rsp_out.valid ? DATA_W'(rsp_out.rdata) : '0;

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else if (clr_ok) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      if (!req_we)        rd_cnt  <= rd_cnt + 32'd1;
      if (req_we && !err) wr_cnt  <= wr_cnt + 32'd1;
      if (err)            err_cnt <= err_cnt + 32'd1;
    end
  end
`endif

endmodule
